// File: rtl/clz_denorm_if.sv
// Handshake bundle for clz_denorm: word/count in, reconstructed word out.
// out_sticky exists only when CLZ_DENORM_STICKY_EN is defined.
interface clz_denorm_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_norm;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
`ifdef CLZ_DENORM_STICKY_EN
  logic             out_sticky;
`endif

  // Producer/consumer side (testbench or upstream logic)
  modport master (
    output in_valid, in_norm, in_cnt, out_ready,
    input  in_ready, out_valid, out_data, out_err
`ifdef CLZ_DENORM_STICKY_EN
    , input out_sticky
`endif
  );

  // Shifter side
  modport slave (
    input  in_valid, in_norm, in_cnt, out_ready,
    output in_ready, out_valid, out_data, out_err
`ifdef CLZ_DENORM_STICKY_EN
    , output out_sticky
`endif
  );
endinterface

// File: rtl/clz_denorm.sv
// Two-stage denormalizer: out_data = in_norm >> in_cnt, coarse byte shift then fine bit shift.
// Optional CLZ_DENORM_STICKY_EN adds out_sticky (OR of all bits shifted out).
module clz_denorm #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  clz_denorm_if.slave    bus
);

  localparam int NLVL = 3;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] norm;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;
  logic [2:0]       s1_fine_reg;
  logic             s1_err_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_data_reg;
  logic             s2_err_reg;

  logic             s2_advance;
  logic             s1_advance;
  logic             in_err;
  logic             cnt_is_full;
  logic             cnt_over;

  assign cnt  = bus.in_cnt;
  assign norm = bus.in_norm;

  // Each stage may load whenever the stage ahead of it can make room this cycle.
  assign s2_advance = !s2_valid_reg || bus.out_ready;
  assign s1_advance = !s1_valid_reg || s2_advance;
  assign bus.in_ready = s1_advance;

  // Consistency check between normalized word and claimed count.
  assign cnt_is_full = (cnt == CNT_W'(WIDTH));
  assign cnt_over    = (cnt >  CNT_W'(WIDTH));
  assign in_err = cnt_over
                | (cnt_is_full & (|norm))
                | (!cnt_over & !cnt_is_full & !norm[WIDTH-1]);

  // Coarse shifter: levels of 8, 16, 32 bits driven by cnt[3], cnt[4], cnt[5].
  logic [WIDTH-1:0] coarse [0:NLVL];
  assign coarse[0] = norm;

  genvar gi;
  generate
    for (gi = 0; gi < NLVL; gi++) begin : g_coarse
      localparam int SH = 8 << gi;
      if (SH < WIDTH) begin : g_part
        assign coarse[gi+1] = cnt[3+gi] ? (coarse[gi] >> SH) : coarse[gi];
      end else begin : g_all
        assign coarse[gi+1] = cnt[3+gi] ? '0 : coarse[gi];
      end
    end
  endgenerate

  // Fine shifter: levels of 1, 2, 4 bits driven by the registered low count bits.
  logic [WIDTH-1:0] fine [0:NLVL];
  assign fine[0] = s1_data_reg;

  generate
    for (gi = 0; gi < NLVL; gi++) begin : g_fine
      localparam int SH = 1 << gi;
      assign fine[gi+1] = s1_fine_reg[gi] ? (fine[gi] >> SH) : fine[gi];
    end
  endgenerate

`ifdef CLZ_DENORM_STICKY_EN
  // Bits lost at each shifter level; the union is the sticky bit.
  logic [NLVL-1:0] coarse_lost;
  logic [NLVL-1:0] fine_lost;
  logic            s1_sticky_reg;
  logic            s2_sticky_reg;

  generate
    for (gi = 0; gi < NLVL; gi++) begin : g_coarse_lost
      localparam int SH = 8 << gi;
      if (SH < WIDTH) begin : g_part
        assign coarse_lost[gi] = cnt[3+gi] & (|coarse[gi][SH-1:0]);
      end else begin : g_all
        assign coarse_lost[gi] = cnt[3+gi] & (|coarse[gi]);
      end
    end
    for (gi = 0; gi < NLVL; gi++) begin : g_fine_lost
      localparam int SH = 1 << gi;
      assign fine_lost[gi] = s1_fine_reg[gi] & (|fine[gi][SH-1:0]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sticky_reg <= 1'b0;
      s2_sticky_reg <= 1'b0;
    end else begin
      if (s1_advance && bus.in_valid) begin
        s1_sticky_reg <= |coarse_lost;
      end
      if (s2_advance && s1_valid_reg) begin
        s2_sticky_reg <= s1_sticky_reg | (|fine_lost);
      end
    end
  end

  assign bus.out_sticky = s2_sticky_reg;
`endif

  // Stage 1: coarse-shifted word, residual fine count, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_fine_reg  <= '0;
      s1_err_reg   <= 1'b0;
    end else if (s1_advance) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_reg <= coarse[NLVL];
        s1_fine_reg <= cnt[2:0];
        s1_err_reg  <= in_err;
      end
    end
  end

  // Stage 2: result registers; held unchanged while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= fine[NLVL];
        s2_err_reg  <= s1_err_reg;
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_data  = s2_data_reg;
  assign bus.out_err   = s2_err_reg;

endmodule

// File: tb/tb_clz_denorm.sv
// Directed self-checking bench for clz_denorm: reset, shifts, errors, backpressure, flush.
// Sticky checks compile in when CLZ_DENORM_STICKY_EN is defined.
module tb_clz_denorm;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  clz_denorm_if bus ();

  clz_denorm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz32(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) return 31 - i;
    end
    return 32;
  endfunction

  // Single transfer into an empty pipe with out_ready high; samples the output two edges later.
  task automatic xfer(input logic [31:0] norm, input logic [5:0] cnt,
                      output logic v, output logic [31:0] d, output logic e, output logic s);
    bus.in_valid = 1'b1;
    bus.in_norm  = norm;
    bus.in_cnt   = cnt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    v = bus.out_valid;
    d = bus.out_data;
    e = bus.out_err;
`ifdef CLZ_DENORM_STICKY_EN
    s = bus.out_sticky;
`else
    s = 1'b0;
`endif
    @(posedge clk); #1;
    $display("xfer norm=%h cnt=%0d -> valid=%b data=%h err=%b sticky=%b", norm, cnt, v, d, e, s);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_norm   = 32'h8000_0000;
    bus.in_cnt    = 6'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data);
    end
    n_checks++;
    if (bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    $display("reset released: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_directed();
    logic [31:0] nv [4];
    logic [5:0]  cv [4];
    logic [31:0] dv [4];
    logic v, e, s;
    logic [31:0] d;
    nv = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'h0000_0000};
    cv = '{6'd0, 6'd31, 6'd4, 6'd32};
    dv = '{32'h8000_0000, 32'h0000_0001, 32'h0F00_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      xfer(nv[i], cv[i], v, d, e, s);
      n_checks++;
      if (v !== 1'b1) begin
        n_fail++; $display("FAIL directed%0d_valid: got %b expected 1", i, v);
      end
      n_checks++;
      if (d !== dv[i]) begin
        n_fail++; $display("FAIL directed%0d_data: got %h expected %h", i, d, dv[i]);
      end
      n_checks++;
      if (e !== 1'b0) begin
        n_fail++; $display("FAIL directed%0d_err: got %b expected 0", i, e);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] nv [3];
    logic [5:0]  cv [3];
    logic [31:0] dv [3];
    logic v, e, s;
    logic [31:0] d;
    nv = '{32'h4000_0000, 32'h0000_0001, 32'h8000_0000};
    cv = '{6'd3, 6'd32, 6'd40};
    dv = '{32'h0800_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      xfer(nv[i], cv[i], v, d, e, s);
      n_checks++;
      if (v !== 1'b1) begin
        n_fail++; $display("FAIL error%0d_valid: got %b expected 1", i, v);
      end
      n_checks++;
      if (d !== dv[i]) begin
        n_fail++; $display("FAIL error%0d_data: got %h expected %h", i, d, dv[i]);
      end
      n_checks++;
      if (e !== 1'b1) begin
        n_fail++; $display("FAIL error%0d_err: got %b expected 1", i, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] src [8];
    logic [31:0] nv  [8];
    logic [5:0]  cv  [8];
    int idx, oidx, c;
    logic in_fire, out_fire, stalled, prev_stalled, drop_seen;
    logic [31:0] held, got;
    for (int i = 0; i < 8; i++) begin
      src[i] = ($urandom | 32'h1) >> $urandom_range(0, 31);
      cv[i]  = 6'(clz32(src[i]));
      nv[i]  = (cv[i] == 6'd32) ? 32'h0 : (src[i] << cv[i]);
    end
    idx = 0; oidx = 0; c = 0;
    prev_stalled = 1'b0; drop_seen = 1'b0; held = '0;
    while (oidx < 8 && c < 60) begin
      bus.out_ready = !(c >= 3 && c <= 7);
      bus.in_valid  = (idx < 8);
      bus.in_norm   = (idx < 8) ? nv[idx] : 32'h0;
      bus.in_cnt    = (idx < 8) ? cv[idx] : 6'd0;
      #4;
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      got      = bus.out_data;
      stalled  = bus.out_valid && !bus.out_ready;
      if (stalled && prev_stalled) begin
        n_checks++;
        if (got !== held) begin
          n_fail++; $display("FAIL bp_stable: got %h expected %h", got, held);
        end
      end
      if (stalled) held = got;
      prev_stalled = stalled;
      if (!drop_seen && bus.in_valid && !bus.in_ready) begin
        drop_seen = 1'b1;
        n_checks++;
        if ((idx - oidx) !== 2) begin
          n_fail++; $display("FAIL bp_held_words: got %0d expected 2", idx - oidx);
        end
      end
      @(posedge clk); #1;
      if (in_fire) idx++;
      if (out_fire) begin
        $display("bp out #%0d data=%h expected=%h", oidx, got, src[oidx]);
        n_checks++;
        if (got !== src[oidx]) begin
          n_fail++; $display("FAIL bp_data%0d: got %h expected %h", oidx, got, src[oidx]);
        end
        oidx++;
      end
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (oidx !== 8) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 8", oidx);
    end
    n_checks++;
    if (drop_seen !== 1'b1) begin
      n_fail++; $display("FAIL bp_in_ready_drop: got %b expected 1", drop_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midflight_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_norm   = 32'h8000_0000;
    bus.in_cnt    = 6'd1;
    @(posedge clk); #1;
    bus.in_norm   = 32'hC000_0000;
    bus.in_cnt    = 6'd2;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_valid: got %b expected 1", bus.out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost%0d: got %b data %h expected 0", i, bus.out_valid, bus.out_data);
      end
    end
    $display("mid-flight reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

`ifdef CLZ_DENORM_STICKY_EN
  task automatic test_sticky();
    logic v, e, s;
    logic [31:0] d;
    xfer(32'h8000_0001, 6'd1, v, d, e, s);
    n_checks++;
    if (d !== 32'h4000_0000) begin
      n_fail++; $display("FAIL sticky0_data: got %h expected 40000000", d);
    end
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++; $display("FAIL sticky0_sticky: got %b expected 1", s);
    end
    xfer(32'h8000_0000, 6'd8, v, d, e, s);
    n_checks++;
    if (d !== 32'h0080_0000) begin
      n_fail++; $display("FAIL sticky1_data: got %h expected 00800000", d);
    end
    n_checks++;
    if (s !== 1'b0) begin
      n_fail++; $display("FAIL sticky1_sticky: got %b expected 0", s);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_midflight_reset();
`ifdef CLZ_DENORM_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clz_denorm.md
Name: clz_denorm

Overview:
- Inverse companion of the 32-bit leading-zero counter.
- Accepts a normalized word (MSB set) plus a leading-zero count, and reconstructs the original word by a logical right shift of the count.
- Two-stage pipelined barrel shifter with valid/ready handshake on both sides.
- Sits after the normalize/arith datapath, wherever a left-normalized value must be restored.

Parameters:
- WIDTH, 32, data width; must be 32 (count encoding 0..32 is fixed to 6 bits).
- CNT_W, 6, count width; must be 6.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input word/count valid
- in_ready  output  1  block can accept input this cycle
- in_norm  input  32  normalized word; bit 31 expected 1 unless in_cnt == 32
- in_cnt  input  6  leading-zero count, legal range 0..32
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  32  reconstructed word = in_norm >> in_cnt (logical)
- out_err  output  1  input inconsistency flag, qualified by out_valid

Behaviour:
- Interface
  - One clock domain; synchronous active-low reset on rst_n.
  - Transfer occurs on a rising clk edge when valid && ready.
- Pipeline
  - S1 registers in_norm shifted right by in_cnt[5:3]*8 (coarse byte shift), plus in_cnt[2:0] and err.
  - S2 applies the fine shift in_cnt[2:0] and drives out_data, out_err, out_valid.
  - Each stage has its own valid bit.
  - Latency: 2 cycles from input handshake to out_valid when out_ready is held 1.
  - Throughput: 1 per cycle.
- Flow control
  - in_ready = !s1_valid || s2_advance, where s2_advance = !s2_valid || out_ready.
  - S1 moves into S2 only when s2_advance.
  - Held results (out_valid=1, out_ready=0) keep out_data and out_err stable until accepted.
  - No bubbles are inserted when both ends are always ready; no data is lost or duplicated under any ready pattern.
- Arithmetic
  - cnt 0..31: out_data = in_norm >> cnt, zero fill.
  - cnt == 32: out_data = 0.
  - cnt 33..63: out_data = 0 and out_err = 1 (saturate).
- Error rules
  - out_err = 1 when cnt < 32 and in_norm[31] == 0.
  - out_err = 1 when cnt == 32 and in_norm != 0.
  - out_err = 1 when cnt > 32.
  - Otherwise out_err = 0.
  - Errors never stall the pipe.
- Reset
  - rst_n low at a clock edge clears s1_valid, s2_valid, out_data=0, out_err=0, out_valid=0, and drives in_ready=1 from the next cycle.
  - Reset mid-operation discards any in-flight words; no partial result is emitted afterwards.
- Simultaneous events
  - Input accept and output drain in the same cycle with a full pipe are legal and keep throughput at 1.

Optional Feature:
- Macro: CLZ_DENORM_STICKY_EN.
- Defined:
  - Extra output port out_sticky (1 bit) aligned with out_data.
  - out_sticky = OR of all in_norm bits shifted out (bits below position cnt).
  - For cnt >= 32, out_sticky = |in_norm.
  - The coarse-stage OR is carried through S1 and combined with the fine-stage OR in S2; latency is unchanged.
- Undefined: port absent, no sticky logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0; in_ready=1 on the first cycle after release.
- Directed values, out_ready=1:
  - norm=0x80000000, cnt=0 -> out_data 0x80000000, err 0, 2 cycles later.
  - norm=0x80000000, cnt=31 -> out_data 0x00000001.
  - norm=0xF0000000, cnt=4 -> out_data 0x0F000000.
  - norm=0x00000000, cnt=32 -> out_data 0, err 0.
- Errors:
  - norm=0x40000000, cnt=3 -> err 1.
  - norm=0x00000001, cnt=32 -> out_data 0, err 1.
  - norm=0x80000000, cnt=40 -> out_data 0, err 1.
- Backpressure: stream 8 words (random valid cnt), out_ready=0 for cycles 3..7 -> in_ready drops after 2 words are held. All 8 outputs arrive in order, each equal to its CLZ round-trip source, and out_data stays stable while stalled.
- Mid-flight reset: 2 words in pipe, pulse rst_n=0 one cycle -> out_valid=0 next cycle and neither word appears.
- Sticky (macro defined): norm=0x80000001, cnt=1 -> out_data 0x40000000, sticky 1; norm=0x80000000, cnt=8 -> sticky 0.
